// File: rtl/booth_arb_pkg.sv
// Shared types and defaults for the booth_arbiter slice: FSM state
// encoding, default operand width / requester count, and the ID-width helper.
package booth_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int BOOTH_BITS = 32;
    localparam int BOOTH_NREQ = 4;

    // Width of a requester index; never narrower than one bit.
    function automatic int calc_idw(input int nreq);
        return (nreq < 2) ? 1 : $clog2(nreq);
    endfunction

endpackage

// File: rtl/booth.sv
// Combinational radix-4 Booth multiplier: signed BITS x BITS -> signed 2*BITS.
// The multiplier is sign-extended to an odd number of bits so each digit
// window {y[2j+1], y[2j], y[2j-1]} exists, including for odd BITS.
module booth #(
    parameter int BITS = 32
) (
    input  logic [BITS-1:0]   x,
    input  logic [BITS-1:0]   y,
    output logic [2*BITS-1:0] result
);

    localparam int PW   = 2 * BITS;
    localparam int NDIG = (BITS + 1) / 2;
    localparam int YW   = 2 * NDIG + 1;

    logic [PW-1:0] xe;
    logic [YW-1:0] yz;
    logic [YW-1:0] ysh;
    logic [PW-1:0] pp;
    logic [PW-1:0] acc;

    // Recode the multiplier into radix-4 digits and sum the shifted partial products.
    always_comb begin
        xe  = {{BITS{x[BITS-1]}}, x};
        yz  = YW'($signed({y, 1'b0}));
        ysh = '0;
        pp  = '0;
        acc = '0;
        for (int j = 0; j < NDIG; j++) begin
            ysh = yz >> (2 * j);
            case (ysh[2:0])
                3'b001, 3'b010: pp = xe;
                3'b011:         pp = xe << 1;
                3'b100:         pp = -(xe << 1);
                3'b101, 3'b110: pp = -xe;
                default:        pp = '0;
            endcase
            acc = acc + (pp << (2 * j));
        end
        result = acc;
    end

endmodule

// File: rtl/booth_arbiter.sv
// Round-robin arbiter sharing one booth multiplier between NREQ requesters.
// Optional feature macro: BOOTH_ARB_ZERO_BYPASS_EN -- when defined, a zero
// operand skips the CALC cycle and the response carries a zero product.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Requesters hold req_valid and operands stable until their
// req_ready is seen; req_ready is one-hot or zero and only ever high in IDLE.
// The response port holds rsp_valid, rsp_id and rsp_result stable until
// rsp_ready is seen; rsp_ready never feeds back into req_ready.
module booth_arbiter
    import booth_arb_pkg::*;
#(
    parameter int  BITS = BOOTH_BITS,
    parameter int  NREQ = BOOTH_NREQ,
    localparam int IDW  = calc_idw(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*BITS-1:0] req_x,
    input  logic [NREQ*BITS-1:0] req_y,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [2*BITS-1:0]    rsp_result,
    output state_t               dbg_state
);

    state_t              state;
    logic [IDW-1:0]      ptr;
    logic [IDW-1:0]      id_q;
    logic [BITS-1:0]     x_q;
    logic [BITS-1:0]     y_q;
    logic [2*BITS-1:0]   res_q;
    logic [2*BITS-1:0]   prod;

    logic                grant_any;
    logic [IDW-1:0]      grant_id;
    logic [IDW-1:0]      cand;
    logic [BITS-1:0]     gx;
    logic [BITS-1:0]     gy;

    // Search from the requester after the last winner and take the first valid one.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        cand      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDW'((int'(ptr) + k) % NREQ);
            if (!grant_any && req_valid[cand]) begin
                grant_any = 1'b1;
                grant_id  = cand;
            end
        end
    end

    // Operands of the current winner, picked out of the flat request buses.
    always_comb begin
        gx = BITS'(req_x >> (int'(grant_id) * BITS));
        gy = BITS'(req_y >> (int'(grant_id) * BITS));
    end

    // Accept only while idle, so at most one operation is ever in flight.
    always_comb begin
        req_ready = '0;
        if (state == IDLE && grant_any) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    booth #(
        .BITS(BITS)
    ) u_booth (
        .x      (x_q),
        .y      (y_q),
        .result (prod)
    );

    // Control FSM: capture on accept, register the product, hold until consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= IDW'(NREQ - 1);
            id_q  <= '0;
            x_q   <= '0;
            y_q   <= '0;
            res_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        x_q  <= gx;
                        y_q  <= gy;
                        id_q <= grant_id;
                        ptr  <= grant_id;
`ifdef BOOTH_ARB_ZERO_BYPASS_EN
                        if (gx == '0 || gy == '0) begin
                            res_q <= '0;
                            state <= RESP;
                        end else begin
                            state <= CALC;
                        end
`else
                        state <= CALC;
`endif
                    end
                end
                CALC: begin
                    res_q <= prod;
                    state <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rsp_valid  = (state == RESP);
    assign rsp_id     = id_q;
    assign rsp_result = res_q;
    assign dbg_state  = state;

endmodule
